// File: rtl/scan_seq_pkg.sv
// Shared types for the scan chain sequencer: FSM state encoding and the
// scan-enable polarity used when driving the chain.
package scan_seq_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      CAPT = 3'd2,
      UNLD = 3'd3,
      RESP = 3'd4
   } state_t;

   localparam logic SE_SHIFT = 1'b1;

endpackage

// File: rtl/scan_phase_cnt.sv
// Loadable down-counter timing each sequencer phase; o_zero marks the
// final edge of the phase. Load wins over enable and the count never wraps.
module scan_phase_cnt #(
   parameter int CNT_W = 6
) (
   input  logic             i_clk,
   input  logic             i_srst,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_en,
   output logic             o_zero
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_srst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_en && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/scan_chain_seq.sv
// Scan chain sequencer: loads a pattern MSB first, pulses functional capture,
// unloads the response from the chain tail and returns it over valid/ready.
module scan_chain_seq #(
   parameter int CHAIN_LEN      = 32,
   parameter int CAPTURE_CYCLES = 1
) (
   input  logic                 CP,
   input  logic                 RST,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [CHAIN_LEN-1:0] cmd_pat,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [CHAIN_LEN-1:0] rsp_data,
   output logic                 scan_se,
   output logic                 scan_si,
   input  logic                 scan_so,
   output logic                 busy
);

   import scan_seq_pkg::*;

   localparam int               CNT_W      = $clog2(CHAIN_LEN + 1);
   localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(CHAIN_LEN - 1);
   localparam logic [CNT_W-1:0] LAST_CAPT  = CNT_W'(CAPTURE_CYCLES - 1);

   state_t                 r_state,     w_state_next;
   logic [CHAIN_LEN-1:0]   r_pat,       w_pat_next;
   logic [CHAIN_LEN-1:0]   r_shreg,     w_shreg_next;
   logic [CHAIN_LEN-1:0]   r_rsp_data,  w_rsp_data_next;
   logic                   r_rsp_valid, w_rsp_valid_next;
   logic                   r_cmd_ready, w_cmd_ready_next;
   logic                   r_scan_se,   w_scan_se_next;
   logic                   r_scan_si,   w_scan_si_next;
   logic                   r_busy,      w_busy_next;

   logic                   w_cnt_load;
   logic [CNT_W-1:0]       w_cnt_val;
   logic                   w_cnt_en;
   logic                   w_cnt_zero;

   scan_phase_cnt #(
      .CNT_W (CNT_W)
   ) u_phase_cnt (
      .i_clk      (CP),
      .i_srst     (RST),
      .i_load     (w_cnt_load),
      .i_load_val (w_cnt_val),
      .i_en       (w_cnt_en),
      .o_zero     (w_cnt_zero)
   );

   always_ff @(posedge CP) begin
      if (RST) begin
         r_state     <= IDLE;
         r_pat       <= '0;
         r_shreg     <= '0;
         r_rsp_data  <= '0;
         r_rsp_valid <= 1'b0;
         r_cmd_ready <= 1'b1;
         r_scan_se   <= 1'b0;
         r_scan_si   <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_pat       <= w_pat_next;
         r_shreg     <= w_shreg_next;
         r_rsp_data  <= w_rsp_data_next;
         r_rsp_valid <= w_rsp_valid_next;
         r_cmd_ready <= w_cmd_ready_next;
         r_scan_se   <= w_scan_se_next;
         r_scan_si   <= w_scan_si_next;
         r_busy      <= w_busy_next;
      end
   end

   // scan_se/scan_si are set one edge ahead so each shift edge sees the
   // registered value it needs; the counter is reloaded on every phase entry.
   always_comb begin
      w_state_next     = r_state;
      w_pat_next       = r_pat;
      w_shreg_next     = r_shreg;
      w_rsp_data_next  = r_rsp_data;
      w_rsp_valid_next = r_rsp_valid;
      w_scan_se_next   = r_scan_se;
      w_scan_si_next   = r_scan_si;
      w_cnt_load       = 1'b0;
      w_cnt_val        = LAST_SHIFT;
      w_cnt_en         = 1'b0;

      if (r_rsp_valid && rsp_ready) begin
         w_rsp_valid_next = 1'b0;
      end

      case (r_state)
         IDLE: begin
            if (cmd_valid && r_cmd_ready) begin
               w_state_next   = LOAD;
               w_pat_next     = cmd_pat;
               w_scan_se_next = SE_SHIFT;
               w_scan_si_next = cmd_pat[CHAIN_LEN-1];
               w_cnt_load     = 1'b1;
               w_cnt_val      = LAST_SHIFT;
            end
         end
         LOAD: begin
            w_cnt_en       = 1'b1;
            w_pat_next     = {r_pat[CHAIN_LEN-2:0], r_pat[CHAIN_LEN-1]};
            w_scan_si_next = r_pat[CHAIN_LEN-2];
            if (w_cnt_zero) begin
               w_state_next   = CAPT;
               w_scan_se_next = ~SE_SHIFT;
               w_scan_si_next = 1'b0;
               w_cnt_load     = 1'b1;
               w_cnt_val      = LAST_CAPT;
            end
         end
         CAPT: begin
            w_cnt_en = 1'b1;
            if (w_cnt_zero) begin
               w_state_next   = UNLD;
               w_scan_se_next = SE_SHIFT;
               w_scan_si_next = 1'b0;
               w_cnt_load     = 1'b1;
               w_cnt_val      = LAST_SHIFT;
            end
         end
         UNLD: begin
            w_cnt_en     = 1'b1;
            w_shreg_next = {r_shreg[CHAIN_LEN-2:0], scan_so};
            if (w_cnt_zero) begin
               w_state_next   = RESP;
               w_scan_se_next = ~SE_SHIFT;
            end
         end
         RESP: begin
            w_rsp_data_next  = r_shreg;
            w_rsp_valid_next = 1'b1;
            w_state_next     = IDLE;
         end
         default: begin
            w_state_next   = IDLE;
            w_scan_se_next = ~SE_SHIFT;
         end
      endcase

      w_busy_next      = (w_state_next != IDLE);
      w_cmd_ready_next = (w_state_next == IDLE) && !w_rsp_valid_next;
   end

   assign cmd_ready = r_cmd_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;
   assign scan_se   = r_scan_se;
   assign scan_si   = r_scan_si;
   assign busy      = r_busy;

endmodule

// File: tb/tb_scan_chain_seq.sv
// Bench: two sequencers (CAPTURE_CYCLES 1 and 2) each driving a 4-cell scan
// chain model; responses are checked against a queue of expected data.
module tb_scan_chain_seq;

   localparam int N = 4;

   typedef struct {
      int         inst;
      logic [3:0] pat;
      logic       dzero;
      logic       hold;
      int         stall;
      logic [3:0] exp_data;
      int         exp_lat;
      logic [15:0] exp_se;
   } vec_t;

   logic       CP = 1'b0;
   logic       RST;
   logic       dzero;
   logic       cmd_valid [2];
   logic       cmd_ready [2];
   logic [3:0] cmd_pat   [2];
   logic       rsp_valid [2];
   logic       rsp_ready [2];
   logic [3:0] rsp_data  [2];
   logic       scan_se   [2];
   logic       scan_si   [2];
   logic       scan_so   [2];
   logic       busy      [2];

   logic [3:0] exp_q[$];
   int         errors  = 0;
   int         checks  = 0;
   int         rsp_cnt = 0;
   vec_t       vecs[5];

   always #5 CP = ~CP;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_inst
         logic [N-1:0] chain;
         logic [3:0]   exp_v;

         scan_chain_seq #(
            .CHAIN_LEN      (N),
            .CAPTURE_CYCLES (gi + 1)
         ) u_dut (
            .CP        (CP),
            .RST       (RST),
            .cmd_valid (cmd_valid[gi]),
            .cmd_ready (cmd_ready[gi]),
            .cmd_pat   (cmd_pat[gi]),
            .rsp_valid (rsp_valid[gi]),
            .rsp_ready (rsp_ready[gi]),
            .rsp_data  (rsp_data[gi]),
            .scan_se   (scan_se[gi]),
            .scan_si   (scan_si[gi]),
            .scan_so   (scan_so[gi]),
            .busy      (busy[gi])
         );

         always @(posedge CP) begin
            if (scan_se[gi]) chain <= {chain[N-2:0], scan_si[gi]};
            else             chain <= dzero ? '0 : ~chain;
         end
         assign scan_so[gi] = chain[N-1];

         always @(negedge CP) begin
            #2;
            if (RST) begin
               exp_q.delete();
            end else if (rsp_valid[gi] && rsp_ready[gi]) begin
               rsp_cnt++;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL rsp_unexpected inst%0d: got %b expected none", gi, rsp_data[gi]);
               end else begin
                  exp_v = exp_q.pop_front();
                  $display("rsp inst%0d data=%b expected=%b", gi, rsp_data[gi], exp_v);
                  chk("rsp_data", {28'd0, rsp_data[gi]}, {28'd0, exp_v});
               end
            end
         end
      end
   endgenerate

   task automatic tick();
      @(negedge CP);
      #1;
   endtask

   task automatic wait_ready(input int i);
      for (int c = 0; c < 50 && !cmd_ready[i]; c++) tick();
      chk("cmd_ready_wait", {31'd0, cmd_ready[i]}, 32'd1);
   endtask

   task automatic run_vec(input vec_t v);
      int          i = v.inst;
      int          lat = 0;
      int          base = rsp_cnt;
      logic [15:0] se_tr = '0;
      logic        ok_ready = 1'b1;
      logic        got = 1'b0;
      dzero        = v.dzero;
      rsp_ready[i] = (v.stall == 0);
      wait_ready(i);
      cmd_pat[i]   = v.pat;
      cmd_valid[i] = 1'b1;
      exp_q.push_back(v.exp_data);
      tick();
      if (v.hold) cmd_pat[i] = 4'b0001;
      else        cmd_valid[i] = 1'b0;
      chk("busy_after_accept", {31'd0, busy[i]}, 32'd1);
      for (int c = 0; c < 40 && !got; c++) begin
         se_tr = {se_tr[14:0], scan_se[i]};
         if (cmd_ready[i]) ok_ready = 1'b0;
         tick();
         lat++;
         if (rsp_valid[i]) got = 1'b1;
      end
      cmd_valid[i] = 1'b0;
      $display("cmd inst%0d pat=%b latency=%0d se_trace=%b", i, v.pat, lat, se_tr);
      chk("rsp_valid_seen", {31'd0, got}, 32'd1);
      chk("latency", lat, v.exp_lat);
      chk("se_trace", {16'd0, se_tr}, {16'd0, v.exp_se});
      chk("cmd_ready_low_while_busy", {31'd0, ok_ready}, 32'd1);
      chk("busy_low_at_rsp", {31'd0, busy[i]}, 32'd0);
      for (int s = 0; s < v.stall; s++) begin
         tick();
         chk("stall_rsp_valid", {31'd0, rsp_valid[i]}, 32'd1);
         chk("stall_rsp_data", {28'd0, rsp_data[i]}, {28'd0, v.exp_data});
         chk("stall_cmd_ready", {31'd0, cmd_ready[i]}, 32'd0);
      end
      rsp_ready[i] = 1'b1;
      tick();
      chk("rsp_valid_clear", {31'd0, rsp_valid[i]}, 32'd0);
      chk("cmd_ready_back", {31'd0, cmd_ready[i]}, 32'd1);
      for (int c = 0; c < 14; c++) tick();
      chk("one_rsp_per_accept", rsp_cnt - base, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0] p[3];
      int         idx;
      int         base;

      vecs[0] = '{0, 4'b1010, 1'b0, 1'b0, 0, 4'b0101, 10, 16'h03DE};
      vecs[1] = '{1, 4'b1100, 1'b0, 1'b0, 0, 4'b1100, 11, 16'h079E};
      vecs[2] = '{0, 4'b1111, 1'b1, 1'b0, 5, 4'b0000, 10, 16'h03DE};
      vecs[3] = '{0, 4'b0011, 1'b0, 1'b1, 0, 4'b1100, 10, 16'h03DE};
      vecs[4] = '{0, 4'b0110, 1'b0, 1'b0, 0, 4'b1001, 10, 16'h03DE};

      RST   = 1'b1;
      dzero = 1'b0;
      for (int i = 0; i < 2; i++) begin
         cmd_valid[i] = 1'b0;
         cmd_pat[i]   = '0;
         rsp_ready[i] = 1'b1;
      end
      tick();
      tick();
      for (int i = 0; i < 2; i++) begin
         chk("rst_scan_se",   {31'd0, scan_se[i]},   32'd0);
         chk("rst_scan_si",   {31'd0, scan_si[i]},   32'd0);
         chk("rst_rsp_valid", {31'd0, rsp_valid[i]}, 32'd0);
         chk("rst_rsp_data",  {28'd0, rsp_data[i]},  32'd0);
         chk("rst_busy",      {31'd0, busy[i]},      32'd0);
         chk("rst_cmd_ready", {31'd0, cmd_ready[i]}, 32'd1);
      end
      RST = 1'b0;
      tick();

      for (int k = 0; k < 4; k++) run_vec(vecs[k]);

      // Reset asserted ahead of the second load edge aborts the command.
      dzero        = 1'b0;
      rsp_ready[0] = 1'b1;
      wait_ready(0);
      base         = rsp_cnt;
      cmd_pat[0]   = 4'b1111;
      cmd_valid[0] = 1'b1;
      exp_q.push_back(4'b0000);
      tick();
      cmd_valid[0] = 1'b0;
      tick();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      $display("cmd inst0 pat=1111 aborted by reset");
      chk("abort_scan_se",   {31'd0, scan_se[0]},   32'd0);
      chk("abort_busy",      {31'd0, busy[0]},      32'd0);
      chk("abort_cmd_ready", {31'd0, cmd_ready[0]}, 32'd1);
      chk("abort_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
      chk("abort_queue_flushed", exp_q.size(), 0);
      run_vec(vecs[4]);
      chk("abort_no_stray_rsp", rsp_cnt - base, 1);

      // Back-to-back commands with cmd_valid and rsp_ready held high.
      p[0] = 4'b1001;
      p[1] = 4'b0111;
      p[2] = 4'b0010;
      base         = rsp_cnt;
      idx          = 0;
      dzero        = 1'b0;
      rsp_ready[0] = 1'b1;
      cmd_pat[0]   = p[0];
      cmd_valid[0] = 1'b1;
      for (int c = 0; c < 200 && idx < 3; c++) begin
         if (cmd_ready[0]) begin
            exp_q.push_back(~p[idx]);
            $display("cmd inst0 pat=%b back-to-back", p[idx]);
            idx++;
            tick();
            if (idx < 3) cmd_pat[0] = p[idx];
            else         cmd_valid[0] = 1'b0;
         end else begin
            tick();
         end
      end
      cmd_valid[0] = 1'b0;
      chk("b2b_accepts", idx, 3);
      for (int c = 0; c < 60 && (rsp_cnt - base) < 3; c++) tick();
      for (int c = 0; c < 14; c++) tick();
      chk("b2b_rsp_count", rsp_cnt - base, 3);
      chk("b2b_queue_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
